// File: rtl/pc_fetch_loader_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_loader_if
// Purpose : groups the UART word handshake and the instruction-memory write
//           bus of the program-counter / instruction-loader front end.
// Signals :
//   uart_inst  [INST_W]  received instruction word (host -> loader)
//   uart_valid           uart_inst valid this cycle (host -> loader)
//   uart_ready           loader can accept a word this cycle (loader -> host)
//   load_we              instruction-memory write strobe (loader -> memory)
//   load_addr  [PC_W]    instruction-memory write address (loader -> memory)
//   load_data  [INST_W]  instruction-memory write data (loader -> memory)
// Modports: master = host/memory side, slave = loader side.
// ---------------------------------------------------------------------------
interface pc_fetch_loader_if #(
    parameter int PC_W   = 16,
    parameter int INST_W = 16
);
    logic [INST_W-1:0] uart_inst;
    logic              uart_valid;
    logic              uart_ready;
    logic              load_we;
    logic [PC_W-1:0]   load_addr;
    logic [INST_W-1:0] load_data;

    modport master (
        output uart_inst,
        output uart_valid,
        input  uart_ready,
        input  load_we,
        input  load_addr,
        input  load_data
    );

    modport slave (
        input  uart_inst,
        input  uart_valid,
        output uart_ready,
        output load_we,
        output load_addr,
        output load_data
    );
endinterface

// File: rtl/pc_fetch_loader.sv
// ---------------------------------------------------------------------------
// pc_fetch_loader
// Purpose : program-counter / instruction-loader front end for a UART-booted
//           CPU. Incoming words are buffered in a small FIFO and written
//           sequentially into instruction memory. After the host pulses done,
//           the FIFO is drained and the block enters RUN, driving the fetch PC
//           with stall and branch redirect.
// Ports   :
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-low
//   enable         in   run enable; low freezes PC and permits reload
//   done           in   one-cycle pulse: host finished sending the program
//   branch_valid   in   redirect PC to branch_target (RUN only)
//   branch_target  in   redirect address
//   stall          in   hold PC (RUN only)
//   pc             out  current fetch PC
//   mode_run       out  1 while in RUN
//   fifo_count     out  number of buffered words
//   overflow       out  sticky: word offered while not ready in LOAD/DRAIN
//   bus            slave modport: UART handshake + memory write bus
// TEST_BLOCK_POP  : when non-zero the writer never pops, so the FIFO can be
//                   filled to observe the overflow path. Leave at 0 in use.
// ---------------------------------------------------------------------------
module pc_fetch_loader #(
    parameter int PC_W           = 16,
    parameter int INST_W         = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int RESET_PC       = 0,
    parameter int PC_STEP        = 1,
    parameter int TEST_BLOCK_POP = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          done,
    input  logic                          branch_valid,
    input  logic [PC_W-1:0]               branch_target,
    input  logic                          stall,
    output logic [PC_W-1:0]               pc,
    output logic                          mode_run,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    pc_fetch_loader_if.slave              bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0]   PTR_ONE_C  = AW'(1'b1);
    localparam logic [CW-1:0]   CNT_ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0]   CNT_ZERO_C = CW'(1'b0);
    localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [PC_W-1:0] ADDR_ONE_C = PC_W'(1'b1);
    localparam logic [PC_W-1:0] RST_PC_C   = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] STEP_C     = PC_W'(PC_STEP);
    localparam bit              POP_EN_C   = (TEST_BLOCK_POP == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [INST_W-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [CW-1:0]       count_r;

    logic [PC_W-1:0]     pc_r;
    logic [PC_W-1:0]     addr_r;       // address the next popped word goes to
    logic                load_we_r;
    logic [PC_W-1:0]     load_addr_r;
    logic [INST_W-1:0]   load_data_r;
    logic                overflow_r;

    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                ready_s;
    logic                enter_load_s;
    logic                enter_run_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == CNT_ZERO_C);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus FIFO push/pop and handshake control.
    always_comb begin
        state_nxt_s  = state_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        ready_s      = 1'b0;
        enter_load_s = 1'b0;
        enter_run_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // The FIFO is always empty here, so the first word goes straight in.
                if (bus.uart_valid) begin
                    state_nxt_s  = ST_LOAD;
                    push_s       = 1'b1;
                    enter_load_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ready_s = !full_s;
                push_s  = bus.uart_valid && !full_s;
                pop_s   = !empty_s && POP_EN_C;
                if (done) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                pop_s = !empty_s && POP_EN_C;
                // Wait until the last memory write has also been issued.
                if (empty_s && !load_we_r) begin
                    state_nxt_s = ST_RUN;
                    enter_run_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_RUN: begin
                ready_s = !enable;
                if (!enable && bus.uart_valid) begin
                    state_nxt_s  = ST_LOAD;
                    push_s       = 1'b1;
                    enter_load_s = 1'b1;
                end else begin
                    state_nxt_s  = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Load-buffer FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO_C;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {INST_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.uart_inst;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered instruction-memory writer: one popped word per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_we_r   <= 1'b0;
            load_data_r <= {INST_W{1'b0}};
            load_addr_r <= RST_PC_C;
            addr_r      <= RST_PC_C;
        end else begin
            load_we_r <= pop_s;
            if (pop_s) begin
                load_data_r <= fifo_mem_r[rd_ptr_r];
                load_addr_r <= addr_r;
                addr_r      <= addr_r + ADDR_ONE_C;
            end else if (enter_load_s) begin
                // Every (re)load starts writing at the reset address.
                load_addr_r <= RST_PC_C;
                addr_r      <= RST_PC_C;
            end
        end
    end

    // Fetch PC: reset on entry to RUN; branch wins over stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RST_PC_C;
        end else if (enter_run_s) begin
            pc_r <= RST_PC_C;
        end else if ((state_r == ST_RUN) && enable) begin
            if (branch_valid) begin
                pc_r <= branch_target;
            end else if (!stall) begin
                pc_r <= pc_r + STEP_C;
            end
        end
    end

    // Sticky overflow flag, cleared whenever a new load begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (enter_load_s) begin
            overflow_r <= 1'b0;
        end else if (((state_r == ST_LOAD) || (state_r == ST_DRAIN)) &&
                     bus.uart_valid && !ready_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign pc             = pc_r;
    assign mode_run       = (state_r == ST_RUN);
    assign fifo_count     = count_r;
    assign overflow       = overflow_r;
    assign bus.uart_ready = ready_s;
    assign bus.load_we    = load_we_r;
    assign bus.load_addr  = load_addr_r;
    assign bus.load_data  = load_data_r;

endmodule

// File: tb/tb_pc_fetch_loader.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_loader
// Purpose : directed self-checking bench for pc_fetch_loader. Three instances
//           share clock and reset: the main one (16-bit), one with popping
//           blocked to fill the FIFO, and a 4-bit-address one to see the load
//           address wrap after a short program.
// ---------------------------------------------------------------------------
module tb_pc_fetch_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // shared run controls
    logic        enable = 1'b0;
    logic        branch_valid = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] branch_target = 16'h0000;

    // main instance
    logic        done = 1'b0;
    logic [15:0] pc;
    logic        mode_run;
    logic [2:0]  fifo_count;
    logic        overflow;
    pc_fetch_loader_if #(.PC_W(16), .INST_W(16)) bus ();

    pc_fetch_loader #(.PC_W(16), .INST_W(16), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .done(done),
        .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall),
        .pc(pc), .mode_run(mode_run), .fifo_count(fifo_count), .overflow(overflow),
        .bus(bus)
    );

    // pop-blocked instance
    logic        done_b = 1'b0;
    logic [15:0] pc_b;
    logic        mode_run_b;
    logic [2:0]  fifo_count_b;
    logic        overflow_b;
    pc_fetch_loader_if #(.PC_W(16), .INST_W(16)) bus_b ();

    pc_fetch_loader #(.PC_W(16), .INST_W(16), .FIFO_DEPTH(4), .TEST_BLOCK_POP(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .done(done_b),
        .branch_valid(branch_valid), .branch_target(branch_target), .stall(stall),
        .pc(pc_b), .mode_run(mode_run_b), .fifo_count(fifo_count_b), .overflow(overflow_b),
        .bus(bus_b)
    );

    // narrow-address instance
    logic        done_w = 1'b0;
    logic [3:0]  pc_w;
    logic [3:0]  branch_target_w = 4'h0;
    logic        mode_run_w;
    logic [2:0]  fifo_count_w;
    logic        overflow_w;
    pc_fetch_loader_if #(.PC_W(4), .INST_W(16)) bus_w ();

    pc_fetch_loader #(.PC_W(4), .INST_W(16), .FIFO_DEPTH(4)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .done(done_w),
        .branch_valid(branch_valid), .branch_target(branch_target_w), .stall(stall),
        .pc(pc_w), .mode_run(mode_run_w), .fifo_count(fifo_count_w), .overflow(overflow_w),
        .bus(bus_w)
    );

    // memory-write logs
    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          w_cnt = 0;
    logic [3:0]  w_last_addr = 4'h0;
    logic [15:0] w_last_data = 16'h0000;

    always @(posedge clk) begin
        if (bus.load_we) begin
            wa_q.push_back(bus.load_addr);
            wd_q.push_back(bus.load_data);
        end
        if (bus_w.load_we) begin
            w_cnt       <= w_cnt + 1;
            w_last_addr <= bus_w.load_addr;
            w_last_data <= bus_w.load_data;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [15:0] addr,
                             input logic [15:0] data);
        if (idx < wa_q.size()) begin
            check_eq({tag, "_addr"}, wa_q[idx], addr);
            check_eq({tag, "_data"}, wd_q[idx], data);
        end else begin
            check_eq({tag, "_missing"}, wa_q.size(), idx + 1);
        end
    endtask

    task automatic wait_run(input string tag);
        for (int k = 0; k < 40 && !mode_run; k++) @(negedge clk);
        check_eq(tag, mode_run, 1'b1);
    endtask

    // one word per cycle, called and returning on a falling edge
    task automatic send_word(input logic [15:0] w);
        bus.uart_inst  = w;
        bus.uart_valid = 1'b1;
        @(negedge clk);
        bus.uart_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sz;
        bus.uart_inst = 16'h0;   bus.uart_valid = 1'b0;
        bus_b.uart_inst = 16'h0; bus_b.uart_valid = 1'b0;
        bus_w.uart_inst = 16'h0; bus_w.uart_valid = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_load_addr", bus.load_addr, 16'h0000);
        check_eq("rst_load_we", bus.load_we, 1'b0);
        check_eq("rst_load_data", bus.load_data, 16'h0000);
        check_eq("rst_count", fifo_count, 3'd0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_mode_run", mode_run, 1'b0);
        check_eq("rst_ready", bus.uart_ready, 1'b0);
        reset = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // 1: three-word load, write latency, then PC counting
        bus.uart_inst = 16'h1111; bus.uart_valid = 1'b1;
        @(negedge clk);
        check_eq("t1_lat0_count", fifo_count, 3'd1);
        check_eq("t1_lat0_we", bus.load_we, 1'b0);
        check_eq("t1_lat0_ready", bus.uart_ready, 1'b1);
        bus.uart_inst = 16'h2222;
        @(negedge clk);
        check_eq("t1_lat1_we", bus.load_we, 1'b1);
        check_eq("t1_lat1_data", bus.load_data, 16'h1111);
        check_eq("t1_lat1_addr", bus.load_addr, 16'h0000);
        bus.uart_inst = 16'h3333;
        @(negedge clk);
        bus.uart_valid = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_run("t1_run");
        check_eq("t1_pc0", pc, 16'h0000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq("t1_pc_inc", pc, i);
        end
        check_eq("t1_nwrites", wa_q.size(), 3);
        check_log("t1_w0", 0, 16'h0000, 16'h1111);
        check_log("t1_w1", 1, 16'h0001, 16'h2222);
        check_log("t1_w2", 2, 16'h0002, 16'h3333);

        // 3: stall holds, branch beats stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t3_stall_hold", pc, 16'h0003);
        end
        branch_valid = 1'b1; branch_target = 16'h0040;
        @(negedge clk);
        check_eq("t3_branch_stall", pc, 16'h0040);
        branch_valid = 1'b0; stall = 1'b0;
        @(negedge clk);
        check_eq("t3_after_branch", pc, 16'h0041);

        // 4: PC wraps from 0xFFFF to 0; enable low freezes
        branch_valid = 1'b1; branch_target = 16'hFFFF;
        @(negedge clk);
        check_eq("t4_pc_ffff", pc, 16'hFFFF);
        branch_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_pc_wrap", pc, 16'h0000);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("t4_enable_hold", pc, 16'h0000);

        // 5a: word while enabled in RUN is ignored
        enable = 1'b1;
        #1;
        check_eq("t5_ready_en", bus.uart_ready, 1'b0);
        @(negedge clk);
        send_word(16'h5555);
        check_eq("t5_ign_mode", mode_run, 1'b1);
        check_eq("t5_ign_count", fifo_count, 3'd0);
        check_eq("t5_ign_ovf", overflow, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("t5_ign_nwrites", wa_q.size(), 3);

        // 5b: reload with enable low; word offered in DRAIN sets overflow
        enable = 1'b0;
        send_word(16'hABCD);
        check_eq("t5_reload_mode", mode_run, 1'b0);
        check_eq("t5_reload_count", fifo_count, 3'd1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        bus.uart_inst = 16'h7777; bus.uart_valid = 1'b1;
        #1;
        check_eq("t5_drain_ready", bus.uart_ready, 1'b0);
        @(negedge clk);
        bus.uart_valid = 1'b0;
        check_eq("t5_drain_ovf", overflow, 1'b1);
        wait_run("t5_run");
        check_eq("t5_nwrites", wa_q.size(), 4);
        check_log("t5_w", 3, 16'h0000, 16'hABCD);
        check_eq("t5_ovf_sticky", overflow, 1'b1);

        // 2a: six back-to-back words with the writer popping
        for (int i = 0; i < 6; i++) begin
            bus.uart_inst = 16'hA000 + 16'(i); bus.uart_valid = 1'b1;
            @(negedge clk);
            if (i == 0) check_eq("t2_ovf_cleared", overflow, 1'b0);
        end
        bus.uart_valid = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_run("t2_run");
        check_eq("t2_ovf_none", overflow, 1'b0);
        check_eq("t2_nwrites", wa_q.size(), 10);
        for (int i = 0; i < 6; i++) begin
            check_log("t2_w", 4 + i, 16'(i), 16'hA000 + 16'(i));
        end

        // 2b: pop blocked, fifth word is dropped
        for (int i = 0; i < 5; i++) begin
            bus_b.uart_inst = 16'hB000 + 16'(i); bus_b.uart_valid = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                check_eq("t2b_full_count", fifo_count_b, 3'd4);
                check_eq("t2b_full_ready", bus_b.uart_ready, 1'b0);
                check_eq("t2b_full_ovf", overflow_b, 1'b0);
            end
        end
        bus_b.uart_valid = 1'b0;
        check_eq("t2b_ovf", overflow_b, 1'b1);
        check_eq("t2b_count", fifo_count_b, 3'd4);

        // 4b: 17 words into a 4-bit address space wrap back to 0
        for (int i = 0; i < 17; i++) begin
            bus_w.uart_inst = 16'h0100 + 16'(i); bus_w.uart_valid = 1'b1;
            @(negedge clk);
        end
        bus_w.uart_valid = 1'b0;
        done_w = 1'b1;
        @(negedge clk);
        done_w = 1'b0;
        for (int k = 0; k < 40 && !mode_run_w; k++) @(negedge clk);
        check_eq("t4w_run", mode_run_w, 1'b1);
        check_eq("t4w_nwrites", w_cnt, 17);
        check_eq("t4w_last_addr", w_last_addr, 4'h0);
        check_eq("t4w_last_data", w_last_data, 16'h0110);

        // 6: reset during a load discards buffered and pending words
        sz = wa_q.size();
        bus.uart_inst = 16'hC001; bus.uart_valid = 1'b1;
        @(negedge clk);
        bus.uart_inst = 16'hC002;
        @(negedge clk);
        bus.uart_valid = 1'b0;
        check_eq("t6_pre_count", fifo_count, 3'd1);
        check_eq("t6_pre_we", bus.load_we, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_count", fifo_count, 3'd0);
        check_eq("t6_rst_we", bus.load_we, 1'b0);
        check_eq("t6_rst_mode", mode_run, 1'b0);
        check_eq("t6_rst_addr", bus.load_addr, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("t6_no_stale", wa_q.size(), sz);
        check_eq("t6_post_we", bus.load_we, 1'b0);
        check_eq("t6_post_count", fifo_count, 3'd0);
        check_eq("t6_post_mode", mode_run, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
